i2s_mic_rx_mc: RTL and testbench

I2S_MIC_RX_MC -- requirements
Module: i2s_mic_rx_mc

---
 rtl/i2s_mic_rx_mc.sv | 145 ++++++++++++++
 tb/tb_i2s_mic_rx_mc.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_mic_rx_mc.sv
// rtl/i2s_mic_rx_mc.sv - I2S stereo microphone receiver with FWFT sample FIFO (optional I2S_RX_OVF_CNT_EN overflow counter)
module i2s_mic_rx_mc #(
    parameter int CLK_DIV    = 16,
    parameter int SLOT_W     = 32,
    parameter int SAMPLE_W   = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    output logic                          sck,
    output logic                          ws,
    input  logic                          sd,
    output logic [SAMPLE_W-1:0]           m_data,
    output logic                          m_chan,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ovf
`ifdef I2S_RX_OVF_CNT_EN
    ,
    output logic [15:0]                   ovf_cnt
`endif
);

    localparam int DW  = $clog2(CLK_DIV);
    localparam int SBW = $clog2(SLOT_W);
    localparam int BW  = SBW + 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;

    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0]  DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [DW-1:0]  DIV_SAMP = DW'(CLK_DIV / 2 - 1);
    localparam logic [SBW-1:0] LAST_BIT = SBW'(SAMPLE_W);
    localparam logic [LW-1:0]  FULL_LVL = LW'(FIFO_DEPTH);

    logic [DW-1:0]       div_cnt;
    logic [DW-1:0]       div_next;
    logic [BW-1:0]       bit_cnt;
    logic [BW-1:0]       bit_next;
    logic [SBW-1:0]      slot_bit;
    logic                div_wrap;
    logic                samp_edge;

    logic [SAMPLE_W-1:0] shreg;
    logic                push_pend;
    logic                push_chan;

    logic [SAMPLE_W:0]   mem [FIFO_DEPTH];
    logic [LW-1:0]       wr_ptr;
    logic [LW-1:0]       rd_ptr;
    logic                full;
    logic                pop;
    logic                do_push;

    assign div_wrap  = enable && (div_cnt == DIV_LAST);
    assign samp_edge = enable && (div_cnt == DIV_SAMP);
    assign div_next  = div_wrap ? '0 : div_cnt + 1'b1;
    assign bit_next  = bit_cnt + 1'b1;
    assign slot_bit  = bit_cnt[SBW-1:0];

    // Clock divider; sck is registered from the next count so the pin never glitches
    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else begin
            div_cnt <= div_next;
            sck     <= (div_next >= DIV_HALF);
        end
    end

    // Frame bit counter and word select, both advancing on SCK falling
    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            bit_cnt <= '0;
            ws      <= 1'b0;
        end else if (div_wrap) begin
            bit_cnt <= bit_next;
            ws      <= bit_next[SBW];
        end
    end

    // Shift in sample bits on SCK rising; flag a push once the last sample bit is in
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg     <= '0;
            push_pend <= 1'b0;
            push_chan <= 1'b0;
        end else begin
            push_pend <= 1'b0;
            if (samp_edge && (slot_bit != '0) && (slot_bit <= LAST_BIT)) begin
                shreg <= SAMPLE_W'({shreg, sd});
            end
            if (samp_edge && (slot_bit == LAST_BIT)) begin
                push_pend <= 1'b1;
                push_chan <= bit_cnt[SBW];
            end
        end
    end

    assign fifo_level = wr_ptr - rd_ptr;
    assign full       = (fifo_level == FULL_LVL);
    assign m_valid    = (fifo_level != '0);
    assign pop        = m_valid && m_ready;
    assign do_push    = push_pend && (!full || pop);
    assign {m_chan, m_data} = mem[rd_ptr[AW-1:0]];

    // Sample storage; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= {push_chan, shreg};
        end
    end

    // FIFO pointers and overflow pulse; a pop while full makes room for a same-cycle push
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            ovf <= push_pend && full && !pop;
        end
    end

`ifdef I2S_RX_OVF_CNT_EN
    // Saturating count of dropped samples, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (ovf && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_mic_rx_mc.sv
// tb/tb_i2s_mic_rx_mc.sv - directed self-checking bench for i2s_mic_rx_mc
module tb_i2s_mic_rx_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        sck;
    logic        ws;
    logic        sd;
    logic [23:0] m_data;
    logic        m_chan;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  fifo_level;
    logic        ovf;
`ifdef I2S_RX_OVF_CNT_EN
    logic [15:0] ovf_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [23:0] vals [0:63];
    int          mic_pos  = 0;
    int          mic_k    = 0;
    logic        prev_sck = 1'b0;
    int          mic_sb;
    logic [23:0] mic_word;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    i2s_mic_rx_mc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .sck        (sck),
        .ws         (ws),
        .sd         (sd),
        .m_data     (m_data),
        .m_chan     (m_chan),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_level (fifo_level),
        .ovf        (ovf)
`ifdef I2S_RX_OVF_CNT_EN
        ,
        .ovf_cnt    (ovf_cnt)
`endif
    );

    // Microphone model: advances one bit per SCK falling edge, slot k carries vals[k]
    always @(negedge clk) begin
        prev_sck <= sck;
        if (!enable) begin
            if (mic_pos != 0) mic_k <= mic_k + 1;
            mic_pos <= 0;
        end else if (prev_sck && !sck) begin
            if (mic_pos == 31 || mic_pos == 63) mic_k <= mic_k + 1;
            mic_pos <= (mic_pos == 63) ? 0 : mic_pos + 1;
        end
    end

    // Slot bit 0 is the delay bit, bits 1..24 carry the word MSB first
    always_comb begin
        mic_sb   = mic_pos % 32;
        mic_word = vals[mic_k % 64];
        sd       = 1'b0;
        if (mic_sb >= 1 && mic_sb <= 24) sd = mic_word[24 - mic_sb];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 1200 && m_valid !== 1'b1; i++) @(negedge clk);
        check({tag, "_valid"}, 32'(m_valid), 32'(1'b1));
    endtask

    task automatic wait_edge(input bit use_ws, input logic lvl, output int t, output logic on_fall);
        logic p, ps, c;
        p       = use_ws ? ws : sck;
        ps      = sck;
        t       = -100000;
        on_fall = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            c = use_ws ? ws : sck;
            if (c === lvl && p !== lvl) begin
                t       = cyc;
                on_fall = ps && !sck;
                break;
            end
            p  = c;
            ps = sck;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t_r1, t_f, t_r2, t_w1, t_w2, t_wf;
        logic fl1, fl2, fl3, dummy;
        int   k0, kd, ovfs, kk;

        for (int i = 0; i < 64; i++) vals[i] = 24'hC00000 ^ 24'(i * 32'h0F1E2D);
        vals[2] = 24'hA5C3F0;
        vals[3] = 24'h123456;

        rst_n   = 1'b0;
        enable  = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst0_sck",   32'(sck),        32'(1'b0));
        check("rst0_ws",    32'(ws),         32'(1'b0));
        check("rst0_valid", 32'(m_valid),    32'(1'b0));
        check("rst0_level", 32'(fifo_level), 32'(4'd0));
        check("rst0_ovf",   32'(ovf),        32'(1'b0));

        // Run into the right slot with one left sample held, then reset mid-frame
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        repeat (700) @(negedge clk);
        check("pre_level", 32'(fifo_level), 32'(4'd1));
        check("pre_ws",    32'(ws),         32'(1'b1));
        check("pre_chan",  32'(m_chan),     32'(1'b0));
        check("pre_data",  32'(m_data),     32'(24'hC00000));
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst1_sck",   32'(sck),        32'(1'b0));
        check("rst1_ws",    32'(ws),         32'(1'b0));
        check("rst1_valid", 32'(m_valid),    32'(1'b0));
        check("rst1_level", 32'(fifo_level), 32'(4'd0));
        check("rst1_ovf",   32'(ovf),        32'(1'b0));
`ifdef I2S_RX_OVF_CNT_EN
        check("rst1_ovfcnt", 32'(ovf_cnt), 32'(16'd0));
`endif
        rst_n  = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);

        // Basic capture of one stereo frame
        enable  = 1'b1;
        m_ready = 1'b1;
        wait_valid("w0");
        check("w0_chan", 32'(m_chan), 32'(1'b0));
        check("w0_data", 32'(m_data), 32'(24'hA5C3F0));
        @(negedge clk);
        wait_valid("w1");
        check("w1_chan", 32'(m_chan), 32'(1'b1));
        check("w1_data", 32'(m_data), 32'(24'h123456));
        @(negedge clk);

        // Bus clock timing
        wait_edge(1'b0, 1'b1, t_r1, dummy);
        wait_edge(1'b0, 1'b0, t_f,  dummy);
        wait_edge(1'b0, 1'b1, t_r2, dummy);
        check("sck_high",   32'(t_f - t_r1),  32'(8));
        check("sck_period", 32'(t_r2 - t_r1), 32'(16));
        wait_edge(1'b1, 1'b1, t_w1, fl1);
        wait_edge(1'b1, 1'b0, t_wf, fl2);
        wait_edge(1'b1, 1'b1, t_w2, fl3);
        check("ws_rise_on_fall",  32'(fl1), 32'(1'b1));
        check("ws_fall_on_fall",  32'(fl2), 32'(1'b1));
        check("ws_rise2_on_fall", 32'(fl3), 32'(1'b1));
        check("ws_high",   32'(t_wf - t_w1), 32'(512));
        check("ws_period", 32'(t_w2 - t_w1), 32'(1024));

        // Synchronise on a fresh left sample, then stall the output for ten samples
        @(negedge clk);
        k0 = -1;
        for (int i = 0; i < 4; i++) begin
            wait_valid("sync");
            if (m_chan === 1'b0) begin
                k0 = mic_k;
                break;
            end
            @(negedge clk);
        end
        check("sync_left", 32'(k0 >= 0), 32'(1'b1));
        @(negedge clk);
        m_ready = 1'b0;
        ovfs    = 0;
        for (int i = 0; i < 5630; i++) begin
            @(negedge clk);
            if (ovf === 1'b1) ovfs++;
        end
        check("full_level", 32'(fifo_level), 32'(4'd8));
        check("ovf_pulses", 32'(ovfs),       32'(2));
        check("hold_chan",  32'(m_chan),     32'(1'b1));
        check("hold_data",  32'(m_data),     32'(vals[(k0 + 1) % 64]));
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check("pushpop_level", 32'(fifo_level), 32'(4'd8));
        check("pushpop_ovf",   32'(ovf),        32'(1'b0));
`ifdef I2S_RX_OVF_CNT_EN
        check("ovf_cnt", 32'(ovf_cnt), 32'(16'd2));
`endif
        for (int j = 0; j < 8; j++) begin
            kk = (j < 7) ? (k0 + 2 + j) : (k0 + 11);
            check("drain_valid", 32'(m_valid), 32'(1'b1));
            check("drain_chan",  32'(m_chan),  32'(kk % 2));
            check("drain_data",  32'(m_data),  32'(vals[kk % 64]));
            m_ready = 1'b1;
            @(negedge clk);
        end
        check("drain_level", 32'(fifo_level), 32'(4'd0));

        // Drop enable at left slot bit 10 while SCK is high
        for (int i = 0; i < 2000 && mic_pos != 10; i++) @(negedge clk);
        for (int i = 0; i < 20 && sck !== 1'b1; i++) @(negedge clk);
        check("drop_pos", 32'(mic_pos), 32'(10));
        check("drop_sck_hi", 32'(sck), 32'(1'b1));
        kd      = mic_k;
        m_ready = 1'b0;
        enable  = 1'b0;
        @(negedge clk);
        check("drop_sck", 32'(sck), 32'(1'b0));
        check("drop_ws",  32'(ws),  32'(1'b0));
        repeat (600) @(negedge clk);
        check("drop_level", 32'(fifo_level), 32'(4'd0));
        check("drop_valid", 32'(m_valid),    32'(1'b0));
        enable  = 1'b1;
        m_ready = 1'b1;
        wait_valid("reen");
        check("reen_chan", 32'(m_chan), 32'(1'b0));
        check("reen_data", 32'(m_data), 32'(vals[(kd + 1) % 64]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
